m_calc_ctrl: RTL and testbench
==============================

Name: m_calc_ctrl

Overview:
- Entry-sequencing controller for the 4x4-keypad calculator.
- Sits between the keypad scanner/decoder pair (scan-frame strobe, one-hot decode to pushed/code) and the 7-segment display path.
- Debounces decoded key presses over scan frames and emits one event per press.
- Runs the operand/operator/equals state machine and drives the value to display.

Parameters:
- DEB, 3: consecutive scan frames a key state must hold before a press/release is accepted (1..15).
- NDIG, 4: maximum decimal digits per typed operand.
- MAXMAG, 99999999: largest result magnitude allowed; anything larger is an error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- tick  in  1  scan-frame strobe, one clk wide, high once per completed frame
- pushed  in  1  exactly one key down (decoder output)
- code  in  4  decoded key: 0-9 digit, A add, B sub, C mul, D backspace, E clear, F equals
- key_evt  out  1  one-clk pulse per accepted press
- key_code  out  4  code latched with key_evt, held until the next event
- disp_val  out  27  magnitude to display (binary)
- disp_neg  out  1  displayed value is negative
- op_pend  out  2  pending operator: 0 none, 1 add, 2 sub, 3 mul
- err  out  1  error state

Behaviour:
- Reset (rst=0, asynchronous), all outputs and registers clear:
  - key_evt=0, key_code=0, disp_val=0, disp_neg=0, op_pend=0, err=0.
  - State S_A, A=0, B=0, digit count=0, debounce counter=0, debounce state RELEASED.
- Debounce (evaluated only when tick=1):
  - RELEASED: counter increments while pushed=1 and code equals the stored candidate. A code change reloads the candidate and sets counter=1. pushed=0 clears counter.
  - When counter reaches DEB: key_evt=1 and key_code=candidate on the following clk edge, then go to HELD.
  - HELD: counter increments while pushed=0; pushed=1 clears it. Reaching DEB returns to RELEASED.
  - Holding a key produces no repeat. A press lasting fewer than DEB frames produces no event.
- FSM consumes key_evt on the clk after it is asserted. disp_* and op_pend update on that same edge, i.e. 2 clk after the qualifying tick.
- Registers A and B are signed 28-bit.
- Digit entry:
  - val = val*10 + d, digit count +1.
  - Ignored when the count is already NDIG.
  - A leading 0 with val=0 keeps count=0.
- Backspace: val = val/10, count -1 (floored at 0).
- States:
  - S_A: digit/backspace edit A; display A. Operator sets op, B=0, count=0, goes to S_OP. F is ignored.
  - S_OP: display A. A digit starts B (goes to S_B). Another operator replaces op. Backspace and F are ignored.
  - S_B: digit/backspace edit B; display B.
    - F computes R = A op B, goes to S_RES.
    - An operator computes R, sets A=R and the new op, B=0, goes to S_OP (chaining).
  - S_RES: display R (stored in A), op_pend=0.
    - An operator chains as in S_B, with the new op.
    - A digit clears A and starts a new A (goes to S_A).
    - Backspace and F are ignored.
  - S_ERR: err=1, disp_val=0, disp_neg=0. Only E leaves.
- E from any state behaves as reset, except the debounce state is untouched.
- Arithmetic:
  - Compute at 42-bit signed width.
  - If |R| > MAXMAG, go to S_ERR; A and B are unchanged.
  - disp_val = |displayed value|, disp_neg = sign.
- If tick and a consumed event coincide, both are processed; the debounce logic and the FSM are independent.
- Reset asserted mid-sequence aborts immediately. No event is emitted for a key still held at reset release until it has been released for DEB frames.

Test Plan:
- Debounce, accepted press: pushed=1, code=7 for 3 ticks, then held 10 ticks → exactly one key_evt, key_code=7. Release for 2 ticks, then press again → no event. Release for 3 ticks, then press for 3 ticks → second event.
- Debounce, short press: code=5 for 2 ticks, then released → no key_evt, disp_val unchanged.
- Operands: keys 1,2,A,3,4,F → disp_val=46, disp_neg=0.
  - Keys 5 then D → disp_val=0.
  - Keys 12345 → A=1234 (fifth digit ignored).
- Chaining and negatives: 9,B,1,2,C,3,F → after C the display shows 3 with disp_neg=1; after F disp_val=9, disp_neg=1.
- Overflow: 9999,C,9999,C,9999,F → err=1. Digits are ignored while in error. E → err=0, disp_val=0, state S_A.
- Reset: rst=0 for 1 clk while in S_B with pushed=1 → all outputs 0. No key_evt until pushed has been 0 for DEB ticks and the key is then pressed anew.

Source files
------------

// File: rtl/m_calc_ctrl.sv
// m_calc_ctrl: entry-sequencing controller for the 4x4-keypad calculator.
// Debounces decoded key presses over scan frames, emits one event per press
// and runs the operand / operator / equals state machine that drives the
// 7-segment display path.
//
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active-low
//   tick     scan-frame strobe, one clk wide per completed frame
//   pushed   exactly one key is down (decoder output)
//   code     decoded key: 0-9 digit, A add, B sub, C mul, D backspace,
//            E clear, F equals
//   key_evt  one-clk pulse per accepted press
//   key_code code latched with key_evt, held until the next event
//   disp_val magnitude to display
//   disp_neg displayed value is negative
//   op_pend  pending operator: 0 none, 1 add, 2 sub, 3 mul
//   err      error state
module m_calc_ctrl #(
    parameter int DEB    = 3,
    parameter int NDIG   = 4,
    parameter int MAXMAG = 99999999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        pushed,
    input  logic [3:0]  code,
    output logic        key_evt,
    output logic [3:0]  key_code,
    output logic [26:0] disp_val,
    output logic        disp_neg,
    output logic [1:0]  op_pend,
    output logic        err
);

    localparam logic [3:0]  DEB_C  = 4'(DEB);
    localparam logic [3:0]  NDIG_C = 4'(NDIG);
    localparam logic [41:0] MAX_C  = 42'(MAXMAG);

    localparam logic [3:0] K_BS  = 4'hD;
    localparam logic [3:0] K_CLR = 4'hE;
    localparam logic [3:0] K_EQ  = 4'hF;

    typedef enum logic { D_REL = 1'b0, D_HELD = 1'b1 } deb_t;
    typedef enum logic [2:0] { S_A, S_OP, S_B, S_RES, S_ERR } st_t;

    function automatic logic signed [41:0] calc(input logic signed [27:0] a,
                                                input logic signed [27:0] b,
                                                input logic [1:0] op);
        logic signed [41:0] ae;
        logic signed [41:0] be;
        ae = a;
        be = b;
        case (op)
            2'd1:    return ae + be;
            2'd2:    return ae - be;
            2'd3:    return ae * be;
            default: return ae;
        endcase
    endfunction

    function automatic logic too_big(input logic signed [41:0] r);
        logic [41:0] mag;
        mag = r[41] ? 42'(-r) : 42'(r);
        return mag > MAX_C;
    endfunction

    function automatic logic [26:0] mag27(input logic signed [27:0] v);
        return v[27] ? 27'(-v) : 27'(v);
    endfunction

    // ---------------- debounce stage ----------------
    deb_t       deb_st;
    logic [3:0] deb_cnt;
    logic [3:0] cand;
    // Cleared by reset: a key still held at reset release must first be seen
    // released for DEB frames before any press can be accepted.
    logic       armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_st   <= D_REL;
            deb_cnt  <= 4'd0;
            cand     <= 4'd0;
            armed    <= 1'b0;
            key_evt  <= 1'b0;
            key_code <= 4'd0;
        end else begin
            key_evt <= 1'b0;
            if (armed && deb_st == D_REL && deb_cnt == DEB_C) begin
                key_evt  <= 1'b1;
                key_code <= cand;
                deb_st   <= D_HELD;
                deb_cnt  <= 4'd0;
            end else if (tick) begin
                if (!armed || deb_st == D_HELD) begin
                    // waiting for a stable release
                    if (pushed) begin
                        deb_cnt <= 4'd0;
                    end else if (deb_cnt == DEB_C - 4'd1) begin
                        deb_cnt <= 4'd0;
                        deb_st  <= D_REL;
                        armed   <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 4'd1;
                    end
                end else begin
                    if (!pushed) begin
                        deb_cnt <= 4'd0;
                    end else if (code != cand) begin
                        cand    <= code;
                        deb_cnt <= 4'd1;
                    end else begin
                        deb_cnt <= deb_cnt + 4'd1;
                    end
                end
            end
        end
    end

    // ---------------- entry FSM stage ----------------
    st_t               st_q, st_d;
    logic signed [27:0] a_q, a_d, b_q, b_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;

    logic               is_dig, is_op;
    logic signed [27:0] base_v, ent_v, bs_v, src;
    logic [3:0]         base_c, ent_c, bs_c;
    logic signed [41:0] res;
    logic               ovf;
    logic [1:0]         new_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= S_A;
            a_q   <= 28'sd0;
            b_q   <= 28'sd0;
            cnt_q <= 4'd0;
            op_q  <= 2'd0;
        end else begin
            st_q  <= st_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        op_d  = op_q;

        is_dig = key_code <= 4'd9;
        is_op  = key_code >= 4'hA && key_code <= 4'hC;
        new_op = 2'(key_code - 4'd9);

        // The operand being edited; a digit that starts a fresh operand
        // edits from zero.
        case (st_q)
            S_A:     begin base_v = a_q;    base_c = cnt_q; end
            S_B:     begin base_v = b_q;    base_c = cnt_q; end
            default: begin base_v = 28'sd0; base_c = 4'd0;  end
        endcase

        if (base_c == NDIG_C) begin
            ent_v = base_v;
            ent_c = base_c;
        end else begin
            ent_v = base_v * 28'sd10 + $signed({24'd0, key_code});
            ent_c = (base_v == 28'sd0 && key_code == 4'd0) ? base_c : base_c + 4'd1;
        end
        bs_v = base_v / 28'sd10;
        bs_c = (base_c == 4'd0) ? 4'd0 : base_c - 4'd1;

        res = calc(a_q, b_q, op_q);
        ovf = too_big(res);

        if (key_evt) begin
            if (key_code == K_CLR) begin
                st_d  = S_A;
                a_d   = 28'sd0;
                b_d   = 28'sd0;
                cnt_d = 4'd0;
                op_d  = 2'd0;
            end else begin
                case (st_q)
                    S_A: begin
                        if (is_dig) begin
                            a_d = ent_v; cnt_d = ent_c;
                        end else if (key_code == K_BS) begin
                            a_d = bs_v; cnt_d = bs_c;
                        end else if (is_op) begin
                            op_d = new_op; b_d = 28'sd0; cnt_d = 4'd0; st_d = S_OP;
                        end
                    end
                    S_OP: begin
                        if (is_dig) begin
                            b_d = ent_v; cnt_d = ent_c; st_d = S_B;
                        end else if (is_op) begin
                            op_d = new_op;
                        end
                    end
                    S_B: begin
                        if (is_dig) begin
                            b_d = ent_v; cnt_d = ent_c;
                        end else if (key_code == K_BS) begin
                            b_d = bs_v; cnt_d = bs_c;
                        end else if (key_code == K_EQ || is_op) begin
                            if (ovf) begin
                                st_d = S_ERR;
                            end else begin
                                a_d = 28'(res);
                                if (is_op) begin
                                    op_d = new_op; b_d = 28'sd0; cnt_d = 4'd0; st_d = S_OP;
                                end else begin
                                    st_d = S_RES;
                                end
                            end
                        end
                    end
                    S_RES: begin
                        if (is_op) begin
                            op_d = new_op; b_d = 28'sd0; cnt_d = 4'd0; st_d = S_OP;
                        end else if (is_dig) begin
                            a_d = ent_v; cnt_d = ent_c; op_d = 2'd0; st_d = S_A;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- display stage ----------------
    always_comb begin
        src = (st_q == S_B) ? b_q : (st_q == S_ERR) ? 28'sd0 : a_q;
        disp_val = mag27(src);
        disp_neg = src[27];
        op_pend  = (st_q == S_OP || st_q == S_B) ? op_q : 2'd0;
        err      = st_q == S_ERR;
    end

endmodule

// File: tb/tb_m_calc_ctrl.sv
// Bench for m_calc_ctrl: directed key sequences; each accepted press pushes
// its expected display state into a queue that an independent monitor checks.
module tb_m_calc_ctrl;

    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        pushed = 1'b0;
    logic [3:0]  code = 4'd0;
    logic        key_evt;
    logic [3:0]  key_code;
    logic [26:0] disp_val;
    logic        disp_neg;
    logic [1:0]  op_pend;
    logic        err;

    m_calc_ctrl #(.DEB(DEB), .NDIG(4), .MAXMAG(99999999)) dut (
        .clk(clk), .rst(rst), .tick(tick), .pushed(pushed), .code(code),
        .key_evt(key_evt), .key_code(key_code), .disp_val(disp_val),
        .disp_neg(disp_neg), .op_pend(op_pend), .err(err)
    );

    always #5 clk = ~clk;

    logic [34:0] q[$];
    int n_vec = 0;
    int n_miss = 0;
    int n_evt = 0;
    int n_exp = 0;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // monitor: state is compared one clk after each event pulse
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (key_evt === 1'b1) begin
                n_evt++;
                @(negedge clk);
                if (q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_evt: got key_code %0d, required no event", key_code);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("evt%0d", n_evt),
                        {1'b0, key_code, err, op_pend, disp_neg, disp_val}, {1'b0, e});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic frame();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_evt(input logic [3:0] k, input logic [26:0] dv, input logic dn,
                              input logic [1:0] op, input logic e);
        q.push_back({k, e, op, dn, dv});
        n_exp++;
    endtask

    // full press: DEB frames down, DEB frames up
    task automatic key(input logic [3:0] k, input logic [26:0] dv, input logic dn,
                       input logic [1:0] op, input logic e);
        expect_evt(k, dv, dn, op, e);
        code = k; pushed = 1'b1;
        repeat (DEB) frame();
        pushed = 1'b0;
        repeat (DEB) frame();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {2'b0, key_evt, key_code, err, op_pend, disp_neg, disp_val}, 36'd0);
        rst = 1'b1;
        repeat (DEB) frame();

        // debounce: long hold gives one event, short re-press while held gives none
        expect_evt(4'd7, 27'd7, 1'b0, 2'd0, 1'b0);
        code = 4'd7; pushed = 1'b1;
        repeat (13) frame();
        pushed = 1'b0; repeat (2) frame();
        pushed = 1'b1; repeat (3) frame();
        pushed = 1'b0; repeat (3) frame();
        expect_evt(4'd7, 27'd77, 1'b0, 2'd0, 1'b0);
        pushed = 1'b1; repeat (3) frame();
        pushed = 1'b0; repeat (3) frame();
        chk("hold_evt_count", 36'(n_evt), 36'd2);

        // short press
        code = 4'd5; pushed = 1'b1; repeat (2) frame();
        pushed = 1'b0; repeat (3) frame();
        chk("short_evt_count", 36'(n_evt), 36'd2);
        chk("short_disp", 36'(disp_val), 36'd77);

        // 12 + 34 = 46
        key(4'hE, 27'd0, 1'b0, 2'd0, 1'b0);
        key(4'd1, 27'd1, 1'b0, 2'd0, 1'b0);
        key(4'd2, 27'd12, 1'b0, 2'd0, 1'b0);
        key(4'hA, 27'd12, 1'b0, 2'd1, 1'b0);
        key(4'd3, 27'd3, 1'b0, 2'd1, 1'b0);
        key(4'd4, 27'd34, 1'b0, 2'd1, 1'b0);
        key(4'hF, 27'd46, 1'b0, 2'd0, 1'b0);
        // digit after result starts new A, then backspace
        key(4'd5, 27'd5, 1'b0, 2'd0, 1'b0);
        key(4'hD, 27'd0, 1'b0, 2'd0, 1'b0);

        // fifth digit ignored
        key(4'hE, 27'd0, 1'b0, 2'd0, 1'b0);
        key(4'd1, 27'd1, 1'b0, 2'd0, 1'b0);
        key(4'd2, 27'd12, 1'b0, 2'd0, 1'b0);
        key(4'd3, 27'd123, 1'b0, 2'd0, 1'b0);
        key(4'd4, 27'd1234, 1'b0, 2'd0, 1'b0);
        key(4'd5, 27'd1234, 1'b0, 2'd0, 1'b0);

        // 9 - 12 = -3, then * 3 = -9
        key(4'hE, 27'd0, 1'b0, 2'd0, 1'b0);
        key(4'd9, 27'd9, 1'b0, 2'd0, 1'b0);
        key(4'hB, 27'd9, 1'b0, 2'd2, 1'b0);
        key(4'd1, 27'd1, 1'b0, 2'd2, 1'b0);
        key(4'd2, 27'd12, 1'b0, 2'd2, 1'b0);
        key(4'hC, 27'd3, 1'b1, 2'd3, 1'b0);
        key(4'd3, 27'd3, 1'b0, 2'd3, 1'b0);
        key(4'hF, 27'd9, 1'b1, 2'd0, 1'b0);

        // overflow: 9999*9999 = 99980001 fits, *9999 does not
        key(4'hE, 27'd0, 1'b0, 2'd0, 1'b0);
        key(4'd9, 27'd9, 1'b0, 2'd0, 1'b0);
        key(4'd9, 27'd99, 1'b0, 2'd0, 1'b0);
        key(4'd9, 27'd999, 1'b0, 2'd0, 1'b0);
        key(4'd9, 27'd9999, 1'b0, 2'd0, 1'b0);
        key(4'hC, 27'd9999, 1'b0, 2'd3, 1'b0);
        key(4'd9, 27'd9, 1'b0, 2'd3, 1'b0);
        key(4'd9, 27'd99, 1'b0, 2'd3, 1'b0);
        key(4'd9, 27'd999, 1'b0, 2'd3, 1'b0);
        key(4'd9, 27'd9999, 1'b0, 2'd3, 1'b0);
        key(4'hC, 27'd99980001, 1'b0, 2'd3, 1'b0);
        key(4'd9, 27'd9, 1'b0, 2'd3, 1'b0);
        key(4'd9, 27'd99, 1'b0, 2'd3, 1'b0);
        key(4'd9, 27'd999, 1'b0, 2'd3, 1'b0);
        key(4'd9, 27'd9999, 1'b0, 2'd3, 1'b0);
        key(4'hF, 27'd0, 1'b0, 2'd0, 1'b1);
        key(4'd5, 27'd0, 1'b0, 2'd0, 1'b1);
        key(4'hE, 27'd0, 1'b0, 2'd0, 1'b0);

        // reset while in S_B with a key down
        key(4'd1, 27'd1, 1'b0, 2'd0, 1'b0);
        key(4'hA, 27'd1, 1'b0, 2'd1, 1'b0);
        key(4'd2, 27'd2, 1'b0, 2'd1, 1'b0);
        code = 4'd3; pushed = 1'b1;
        frame();
        @(negedge clk); rst = 1'b0;
        #1;
        chk("midreset_outputs", {2'b0, key_evt, key_code, err, op_pend, disp_neg, disp_val}, 36'd0);
        @(negedge clk); rst = 1'b1;
        repeat (DEB + 3) frame();
        chk("held_after_reset_evts", 36'(n_evt), 36'(n_exp));
        pushed = 1'b0; repeat (DEB) frame();
        key(4'd4, 27'd4, 1'b0, 2'd0, 1'b0);

        repeat (20) @(negedge clk);
        chk("queue_drained", 36'(q.size()), 36'd0);
        chk("total_evts", 36'(n_evt), 36'(n_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
